// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder: registered priority/scan encoder, emits set-bit indices of a captured word one beat at a time
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request word handshake, in_data = WIDTH-bit request vector
//   out_valid/out_ready index beat handshake
//   out_idx           binary index of the current set bit
//   out_last          final beat for the current word
//   out_zero          zero-word beat marker (present only when ENC_ZERO_BEAT_EN is defined)
// Parameters: WIDTH (2..256), MODE (0 = priority index only, 1 = scan all set bits),
//   PRIO_MSB (0 = lowest set bit first, 1 = highest set bit first)
// Macro ENC_ZERO_BEAT_EN: an accepted all-zero word yields one out_zero beat instead of being dropped.
module prio_scan_encoder #(
  parameter int WIDTH = 8,
  parameter int MODE = 1,
  parameter int PRIO_MSB = 0,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
`ifdef ENC_ZERO_BEAT_EN
  ,output logic            out_zero
`endif
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [WIDTH-1:0] mask;
  logic zero;
  logic single;
  logic done;
  // Walk towards the winning end so the last hit is the priority bit.
  always_comb begin
    out_idx = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (mask[IDX_W'(PRIO_MSB != 0 ? j : WIDTH - 1 - j)])
        out_idx = IDX_W'(PRIO_MSB != 0 ? j : WIDTH - 1 - j);
    end
  end
  assign single = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = state == SCAN;
  assign out_last = out_valid && (zero || MODE == 0 || single);
  assign done = MODE == 0 || out_last;
`ifdef ENC_ZERO_BEAT_EN
  assign out_zero = out_valid && zero;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask <= '0;
      zero <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid && |in_data) begin
        mask <= in_data;
        state <= SCAN;
      end
`ifdef ENC_ZERO_BEAT_EN
      else if (in_valid) begin
        zero <= 1'b1;
        state <= SCAN;
      end
`endif
    end else if (out_ready) begin
      mask <= done ? '0 : mask & ~(WIDTH'(1) << out_idx);
      zero <= 1'b0;
      state <= done ? IDLE : SCAN;
    end
  end
endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb_prio_scan_encoder: scoreboard bench driving five encoder configurations in lockstep
module tb_prio_scan_encoder;
  logic clk, rst, in_valid, out_ready;
  logic [11:0] in_data;
  logic [4:0] rdy, ov, lst;
  logic [2:0] i0, i1, i2, i3;
  logic [3:0] i4;
`ifdef ENC_ZERO_BEAT_EN
  logic [4:0] zr;
`endif
  int exp_q [5][$];
  int n_vec, n_err;

  prio_scan_encoder #(.WIDTH(8), .MODE(1), .PRIO_MSB(0)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data[7:0]), .out_valid(ov[0]), .out_ready(out_ready), .out_idx(i0), .out_last(lst[0])
`ifdef ENC_ZERO_BEAT_EN
    , .out_zero(zr[0])
`endif
  );
  prio_scan_encoder #(.WIDTH(8), .MODE(1), .PRIO_MSB(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data[7:0]), .out_valid(ov[1]), .out_ready(out_ready), .out_idx(i1), .out_last(lst[1])
`ifdef ENC_ZERO_BEAT_EN
    , .out_zero(zr[1])
`endif
  );
  prio_scan_encoder #(.WIDTH(8), .MODE(0), .PRIO_MSB(0)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data[7:0]), .out_valid(ov[2]), .out_ready(out_ready), .out_idx(i2), .out_last(lst[2])
`ifdef ENC_ZERO_BEAT_EN
    , .out_zero(zr[2])
`endif
  );
  prio_scan_encoder #(.WIDTH(8), .MODE(0), .PRIO_MSB(1)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_data(in_data[7:0]), .out_valid(ov[3]), .out_ready(out_ready), .out_idx(i3), .out_last(lst[3])
`ifdef ENC_ZERO_BEAT_EN
    , .out_zero(zr[3])
`endif
  );
  prio_scan_encoder #(.WIDTH(12), .MODE(1), .PRIO_MSB(0)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[4]),
    .in_data(in_data), .out_valid(ov[4]), .out_ready(out_ready), .out_idx(i4), .out_last(lst[4])
`ifdef ENC_ZERO_BEAT_EN
    , .out_zero(zr[4])
`endif
  );

  always #5 clk = ~clk;

  // Expected beats are encoded as idx | last<<8 | zero<<9.
  task automatic push_word(input logic [11:0] w);
    for (int k = 0; k < 5; k++) begin
      int wd = (k == 4) ? 12 : 8;
      bit md = (k != 2 && k != 3);
      bit pm = (k == 1 || k == 3);
      int m = int'(w) & ((1 << wd) - 1);
      int n = 0;
      int seen = 0;
      for (int j = 0; j < wd; j++) n += (m >> j) & 1;
      if (m == 0) begin
`ifdef ENC_ZERO_BEAT_EN
        exp_q[k].push_back((1 << 8) | (1 << 9));
`endif
      end else begin
        for (int j = 0; j < wd; j++) begin
          int b = pm ? wd - 1 - j : j;
          if (((m >> b) & 1) != 0) begin
            seen++;
            exp_q[k].push_back(b | (((seen == n) || !md) ? (1 << 8) : 0));
            if (!md) break;
          end
        end
      end
    end
  endtask

  // Advance one cycle; every completed beat is popped from its scoreboard queue and compared.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      for (int k = 0; k < 5; k++) begin
        if (ov[k] && out_ready) begin
          int got, e;
          bit zb;
`ifdef ENC_ZERO_BEAT_EN
          zb = zr[k];
`else
          zb = 1'b0;
`endif
          got = (k == 0) ? int'(i0) : (k == 1) ? int'(i1) : (k == 2) ? int'(i2) : (k == 3) ? int'(i3) : int'(i4);
          got = got | (int'(lst[k]) << 8) | (int'(zb) << 9);
          n_vec++;
          if (exp_q[k].size() == 0) begin
            n_err++;
            $display("FAIL beat dut%0d unexpected: got=%h expected none", k, got);
          end else begin
            e = exp_q[k].pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL beat dut%0d: got=%h expected=%h", k, got, e);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] w);
    for (int c = 0; c < 100 && rdy != 5'h1f; c++) tick();
    n_vec++;
    if (rdy !== 5'h1f) begin
      n_err++;
      $display("FAIL send_ready: got=%b expected=11111", rdy);
    end
    in_valid = 1'b1;
    in_data = w;
    push_word(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    bit ok = 0;
    for (int c = 0; c < 400; c++) begin
      if (rdy == 5'h1f && exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
          exp_q[3].size() == 0 && exp_q[4].size() == 0) begin
        ok = 1;
        break;
      end
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    out_ready = 1'b1;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain_timeout: got rdy=%b pending=%0d expected all idle", rdy, exp_q[0].size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({rdy, ov, lst} !== 15'h0 || {i0, i1, i2, i3, i4} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b lst=%b expected all 0", rdy, ov, lst);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (rdy !== 5'h1f || ov !== 5'h0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b ov=%b expected 11111/00000", rdy, ov);
    end
  endtask

  task automatic test_scan();
    send(12'h0A6);
    n_vec++;
    if (rdy !== 5'h0 || ov !== 5'h1f) begin
      n_err++;
      $display("FAIL scan_latency: got rdy=%b ov=%b expected 00000/11111", rdy, ov);
    end
    tick();
    n_vec++;
    if (rdy[3:2] !== 2'b11) begin
      n_err++;
      $display("FAIL mode0_rate: got rdy=%b expected 11 in bits 3:2", rdy);
    end
    tick();
    tick();
    n_vec++;
    if (rdy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL scan_busy: got in_ready=%b expected 0", rdy[0]);
    end
    tick();
    n_vec++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL scan_rate: got rdy=%b expected 1 in bits 1:0", rdy);
    end
    drain(0);
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(12'h081);
    in_valid = 1'b1;
    in_data = 12'h03C;
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (ov[0] !== 1'b1 || i0 !== 3'd0 || lst[0] !== 1'b0 || i1 !== 3'd7 || rdy !== 5'h0) begin
        n_err++;
        $display("FAIL stall_hold: got ov=%b idx0=%0d last0=%b idx1=%0d rdy=%b expected 1/0/0/7/00000",
                 ov[0], i0, lst[0], i1, rdy);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(0);
  endtask

  task automatic test_all_ones();
    send(12'h0FF);
    drain(0);
    send(12'hFFF);
    drain(0);
    send(12'h000);
    drain(0);
  endtask

  task automatic test_reset_mid();
    send(12'h0F0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) exp_q[k].delete();
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (ov !== 5'h0 || rdy !== 5'h1f) begin
      n_err++;
      $display("FAIL reset_mid: got ov=%b rdy=%b expected 00000/11111", ov, rdy);
    end
    send(12'h002);
    drain(0);
  endtask

  task automatic test_wide();
    send(12'h801);
    drain(0);
    for (int r = 0; r < 1000; r++) begin
      logic [11:0] w = 12'($urandom);
      if (r % 7 == 0) w = w & 12'($urandom);
      if (r % 50 == 0) w = 12'h0;
      send(w);
      drain(1);
    end
  endtask

  initial begin
    clk = 0;
    rst = 1;
    in_valid = 0;
    in_data = '0;
    out_ready = 1;
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_scan();
    test_stall();
    test_all_ones();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
